// File: rtl/ins_mem.sv
// Word-organised instruction memory for the IF stage. The read port is combinational and
// addressed by the PC. A synchronous single-word write port is used for program loading.
module ins_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        i_sys_clock,
  input  logic        i_sys_reset,
  input  logic [31:0] i_u_ins_mem_ins_addr,
  input  logic        i_u_ins_mem_wr_en,
  input  logic [31:0] i_u_ins_mem_wr_ins,
  output logic [31:0] o_u_ins_mem_ins
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     word_off;
  logic [31:0]     word_idx;
  logic            in_range;
  logic [IdxW-1:0] mem_idx;
  logic            mem_we;

  // Unsigned subtraction wraps for addresses below the base.
  // The explicit base compare rejects those wrapped results.
  always_comb begin
    word_off = i_u_ins_mem_ins_addr - BASE_ADDR;
    word_idx = word_off >> 2;
    in_range = (i_u_ins_mem_ins_addr >= BASE_ADDR) && (word_idx < DEPTH);
    mem_idx  = word_idx[IdxW-1:0];
    mem_we   = i_u_ins_mem_wr_en && in_range;
  end

  always_comb begin
    o_u_ins_mem_ins = 32'h0000_0000;
    if (in_range) begin
      o_u_ins_mem_ins = mem_q[mem_idx];
    end
  end

  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= i_u_ins_mem_wr_ins;
    end
  end

endmodule

// File: tb/tb_ins_mem.sv
// Bench for ins_mem. A directed vector table runs first. Random traffic follows and is
// checked against an array-based model of the word memory.
module tb_ins_mem;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0040_0000;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 4 * (DEPTH - 1);
  localparam logic [31:0] PAST_ADDR = BASE_ADDR + 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_pre;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [DEPTH];

  ins_mem #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_dut (
    .i_sys_clock         (clk),
    .i_sys_reset         (rst),
    .i_u_ins_mem_ins_addr(addr),
    .i_u_ins_mem_wr_en   (we),
    .i_u_ins_mem_wr_ins  (wdata),
    .o_u_ins_mem_ins     (rdata)
  );

  always #5 clk = ~clk;

  function automatic void add(string n, logic r, logic w, logic [31:0] a, logic [31:0] d,
                              logic cp, logic [31:0] ep, logic [31:0] eq);
    vec_t v;
    v.name = n; v.rst = r; v.we = w; v.addr = a; v.wdata = d;
    v.chk_pre = cp; v.exp_pre = ep; v.exp_post = eq;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  // The model keeps a plain byte address map.
  // Anything outside [BASE, BASE + 4*DEPTH) reads as a NOP.
  function automatic logic [31:0] ref_read(logic [31:0] a);
    longint unsigned off;
    if (a < BASE_ADDR) return 32'h0;
    off = (longint'(a) - longint'(BASE_ADDR)) / 4;
    if (off >= DEPTH) return 32'h0;
    return model[off];
  endfunction

  function automatic void ref_edge(logic r, logic w, logic [31:0] a, logic [31:0] d);
    longint unsigned off;
    if (r) begin
      foreach (model[i]) model[i] = 32'h0;
    end else if (w && a >= BASE_ADDR) begin
      off = (longint'(a) - longint'(BASE_ADDR)) / 4;
      if (off < DEPTH) model[off] = d;
    end
  endfunction

  task automatic step(string n, logic r, logic w, logic [31:0] a, logic [31:0] d,
                      logic cp, logic [31:0] ep, logic [31:0] eq);
    rst = r; we = w; addr = a; wdata = d;
    #1;
    if (cp) check({n, " pre"}, rdata, ep);
    @(posedge clk);
    #1;
    check({n, " post"}, rdata, eq);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE_ADDR + $urandom_range(0, 4 * DEPTH - 1);
      3:       return PAST_ADDR + $urandom_range(0, 15);
      4:       return BASE_ADDR - 1 - $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic        r, w;
    logic [31:0] a, d, ep;

    rst = 1'b0; we = 1'b0; addr = BASE_ADDR; wdata = 32'h0;
    foreach (model[i]) model[i] = 32'h0;

    add("reset",         1, 0, BASE_ADDR,       32'h0,         0, 32'h0,         32'h0);
    add("rd word1",      0, 0, BASE_ADDR + 4,   32'h0,         1, 32'h0,         32'h0);
    add("wr word0",      0, 1, BASE_ADDR,       32'h2009_7FFF, 1, 32'h0,         32'h2009_7FFF);
    add("wr_en low",     0, 0, BASE_ADDR,       32'h0000_4444, 1, 32'h2009_7FFF, 32'h2009_7FFF);
    add("no alias",      0, 0, BASE_ADDR + 4,   32'h0,         1, 32'h0,         32'h0);
    add("misaligned",    0, 0, BASE_ADDR + 2,   32'h0,         1, 32'h2009_7FFF, 32'h2009_7FFF);
    add("oor low wr",    0, 1, 32'h0,           32'hDEAD_BEEF, 1, 32'h0,         32'h0);
    add("oor high wr",   0, 1, PAST_ADDR,       32'hDEAD_BEEF, 1, 32'h0,         32'h0);
    add("word0 kept",    0, 0, BASE_ADDR,       32'h0,         1, 32'h2009_7FFF, 32'h2009_7FFF);
    add("last kept",     0, 0, LAST_ADDR,       32'h0,         1, 32'h0,         32'h0);
    add("wr last",       0, 1, LAST_ADDR,       32'h1234_5678, 1, 32'h0,         32'h1234_5678);
    add("last misalign", 0, 0, LAST_ADDR + 3,   32'h0,         1, 32'h1234_5678, 32'h1234_5678);
    add("wr word1",      0, 1, BASE_ADDR + 4,   32'h1111_1111, 1, 32'h0,         32'h1111_1111);
    add("wr word2",      0, 1, BASE_ADDR + 8,   32'h2222_2222, 1, 32'h0,         32'h2222_2222);
    add("wr word3",      0, 1, BASE_ADDR + 12,  32'h3333_3333, 1, 32'h0,         32'h3333_3333);
    add("rst+wr",        1, 1, BASE_ADDR + 8,   32'hFFFF_FFFF, 1, 32'h2222_2222, 32'h0);
    add("rst word0",     0, 0, BASE_ADDR,       32'h0,         1, 32'h0,         32'h0);
    add("rst word1",     0, 0, BASE_ADDR + 4,   32'h0,         1, 32'h0,         32'h0);
    add("rst word3",     0, 0, BASE_ADDR + 12,  32'h0,         1, 32'h0,         32'h0);
    add("rst last",      0, 0, LAST_ADDR,       32'h0,         1, 32'h0,         32'h0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].chk_pre, vecs[i].exp_pre, vecs[i].exp_post);
    end

    // After the table, memory is all zero, matching the model's initial state.
    for (int k = 0; k < 2000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      w = $urandom_range(0, 1);
      a = rand_addr();
      d = $urandom();
      ep = ref_read(a);
      ref_edge(r, w, a, d);
      step("random", r, w, a, d, 1'b1, ep, ref_read(a));
    end

    // Sweep-read every word so stale or mis-indexed writes show up.
    for (int unsigned j = 0; j < DEPTH; j++) begin
      a = BASE_ADDR + 4 * j;
      step("sweep", 1'b0, 1'b0, a, 32'h0, 1'b1, ref_read(a), ref_read(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
